// File: rtl/lifo_stack.sv
// Synchronous LIFO stack with a registered pop output and push/pop bypass.
// The occupancy counter doubles as the stack pointer, and the flags are decoded from it.
module lifo_stack #(
  parameter int DEPTH      = 12,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_wr,
  input  logic                  wr_en,
  output logic                  lifo_full,
  output logic [DATA_WIDTH-1:0] data_rd,
  input  logic                  rd_en,
  output logic                  lifo_empty
);

  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      count_dec;
  logic [ADDR_W-1:0]     wr_addr;
  logic [ADDR_W-1:0]     rd_addr;
  logic                  push_ok;
  logic                  pop_ok;

  assign lifo_empty = (count == '0);
  assign lifo_full  = (count == CNT_W'(DEPTH));

  assign count_dec = count - CNT_W'(1);
  assign wr_addr   = count[ADDR_W-1:0];
  assign rd_addr   = count_dec[ADDR_W-1:0];

  // Single-sided requests only; a simultaneous push and pop is the bypass case.
  assign push_ok = wr_en && !rd_en && !lifo_full;
  assign pop_ok  = rd_en && !wr_en && !lifo_empty;

  // NOTE: storage has no reset. Its contents are don't-care after reset because
  // count gates every read, and leaving it unreset lets the array map onto RAM.
  always_ff @(posedge clk) begin
    if (rst && push_ok) begin
      mem[wr_addr] <= data_wr;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count   <= '0;
      data_rd <= '0;
    end else begin
      if (wr_en && rd_en) begin
        data_rd <= data_wr;
      end else if (push_ok) begin
        count <= count + CNT_W'(1);
      end else if (pop_ok) begin
        data_rd <= mem[rd_addr];
        count   <= count_dec;
      end
    end
  end

endmodule

// File: tb/tb_lifo_stack.sv
// Self-checking bench for lifo_stack: directed fill/drain/bypass steps, then
// random traffic scored against a queue model of the stack.
module tb_lifo_stack;

  localparam int DEPTH = 12;
  localparam int DW    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] data_wr;
  logic          wr_en;
  logic          rd_en;
  logic          lifo_full;
  logic          lifo_empty;
  logic [DW-1:0] data_rd;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q [$];
  logic [DW-1:0] m_rd;

  lifo_stack #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_wr   (data_wr),
    .wr_en     (wr_en),
    .lifo_full (lifo_full),
    .data_rd   (data_rd),
    .rd_en     (rd_en),
    .lifo_empty(lifo_empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".data_rd"}, 32'(data_rd), 32'(m_rd));
    check({tag, ".empty"}, 32'(lifo_empty), 32'(q.size() == 0));
    check({tag, ".full"}, 32'(lifo_full), 32'(q.size() == DEPTH));
  endtask

  // Drive one cycle from a negedge, update the model at the posedge, and check at the next negedge.
  task automatic apply(input logic r, input logic w, input logic p,
                       input logic [DW-1:0] d, input string tag);
    rst = r; wr_en = w; rd_en = p; data_wr = d;
    @(posedge clk);
    if (!r) begin
      q.delete();
      m_rd = '0;
    end else if (w && p) begin
      m_rd = d;
    end else if (w) begin
      if (q.size() < DEPTH) q.push_back(d);
    end else if (p) begin
      if (q.size() > 0) m_rd = q.pop_back();
    end
    @(negedge clk);
    check_state(tag);
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_wr = '0; m_rd = '0;
    @(negedge clk);

    // Reset held low with a push request asserted must leave the stack empty.
    for (int i = 0; i < 5; i++) apply(1'b0, 1'b1, 1'b0, 8'hC3, "reset");
    apply(1'b1, 1'b0, 1'b0, 8'h00, "release");
    check("release.data_rd_zero", 32'(data_rd), 32'h0);
    check("release.empty_one", 32'(lifo_empty), 32'h1);

    // Fill the stack, then push once more to overflow.
    for (int i = 1; i <= DEPTH; i++) begin
      apply(1'b1, 1'b1, 1'b0, DW'(i), "fill");
      check("fill.full_flag", 32'(lifo_full), 32'(i == DEPTH));
      check("fill.not_empty", 32'(lifo_empty), 32'h0);
    end
    apply(1'b1, 1'b1, 1'b0, 8'hFF, "overflow");
    check("overflow.full_held", 32'(lifo_full), 32'h1);

    // Drain the stack in reverse push order, then pop once more to underflow.
    for (int i = DEPTH; i >= 1; i--) begin
      apply(1'b1, 1'b0, 1'b1, 8'h00, "drain");
      check("drain.order", 32'(data_rd), 32'(i));
    end
    check("drain.empty", 32'(lifo_empty), 32'h1);
    apply(1'b1, 1'b0, 1'b1, 8'h00, "underflow");
    check("underflow.data_held", 32'(data_rd), 32'h01);

    // Bypass with three words stored.
    apply(1'b1, 1'b1, 1'b0, 8'h11, "bp_push");
    apply(1'b1, 1'b1, 1'b0, 8'h22, "bp_push");
    apply(1'b1, 1'b1, 1'b0, 8'h33, "bp_push");
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 1'b1, 1'b1, DW'(8'hA0 + i), "bypass");
      check("bypass.data", 32'(data_rd), 32'(8'hA0 + i));
    end
    apply(1'b1, 1'b0, 1'b1, 8'h00, "bp_pop");
    check("bp_pop.0", 32'(data_rd), 32'h33);
    apply(1'b1, 1'b0, 1'b1, 8'h00, "bp_pop");
    check("bp_pop.1", 32'(data_rd), 32'h22);
    apply(1'b1, 1'b0, 1'b1, 8'h00, "bp_pop");
    check("bp_pop.2", 32'(data_rd), 32'h11);

    // Bypass when the stack is empty and when it is full.
    apply(1'b1, 1'b1, 1'b1, 8'h5A, "bp_empty");
    check("bp_empty.data", 32'(data_rd), 32'h5A);
    check("bp_empty.empty", 32'(lifo_empty), 32'h1);
    for (int i = 0; i < DEPTH; i++) apply(1'b1, 1'b1, 1'b0, DW'($urandom), "bp_fill");
    apply(1'b1, 1'b1, 1'b1, 8'h7E, "bp_full");
    check("bp_full.data", 32'(data_rd), 32'h7E);
    check("bp_full.full", 32'(lifo_full), 32'h1);

    // Random traffic with a mid-sequence reset. The push bias alternates so
    // that both the full and the empty boundary are reached.
    for (int i = 0; i < 600; i++) begin
      int unsigned sel;
      int unsigned push_bias;
      logic w, p;
      sel       = $urandom_range(0, 99);
      push_bias = ((i / 40) % 2 == 0) ? 65 : 25;
      w = 1'b0; p = 1'b0;
      if (sel < 10)                   begin w = 1'b1; p = 1'b1; end
      else if (sel < 10 + push_bias)  w = 1'b1;
      else if (sel < 95)              p = 1'b1;
      if (i == 300) apply(1'b0, w, p, DW'($urandom), "rand_reset");
      else          apply(1'b1, w, p, DW'($urandom), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lifo_stack.md
# lifo_stack

Synchronous last-in-first-out buffer of `DEPTH` entries, each `DATA_WIDTH` bits wide, in a single clock domain. It is used as a push/pop scratch stack between a producer and a consumer. Pop data is registered. A simultaneous push and pop bypasses the stored data: the pushed word goes straight to the read register.

## Interface
Parameters:
- `DEPTH`, default 12: number of storage entries, ≥ 2.
- `DATA_WIDTH`, default 8: word width in bits.

Ports:
- `clk`, input, 1: the only clock; all state updates on its rising edge.
- `rst`, input, 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `data_wr`, input, `DATA_WIDTH`: word to push.
- `wr_en`, input, 1: push request.
- `lifo_full`, output, 1: high when `DEPTH` entries are stored.
- `data_rd`, output, `DATA_WIDTH`: registered pop / bypass data.
- `rd_en`, input, 1: pop request.
- `lifo_empty`, output, 1: high when 0 entries are stored.

## Operation
- **State.**
  - Storage array of `DEPTH` words.
  - Occupancy counter / stack pointer, `count`, range 0..`DEPTH`, width `$clog2(DEPTH+1)`.
  - `data_rd` register.
- **Flags.** Decoded combinationally from `count`:
  - `lifo_empty = (count == 0)`
  - `lifo_full = (count == DEPTH)`
- **Reset** (rising edge with `rst` = 0):
  - `count` = 0, `data_rd` = 0, so `lifo_empty` = 1 and `lifo_full` = 0.
  - Storage contents are not cleared and are don't-care.
  - Reset overrides any concurrent `wr_en`/`rd_en`.
  - A reset mid-sequence discards all stored entries.
- **Edge behaviour** when `rst` = 1, evaluated on each rising edge with `wr_en` and `rd_en` sampled together:
  - **Push only** (`wr_en`=1, `rd_en`=0):
    - If not full, store `data_wr` at index `count`, then `count` += 1.
    - If full, the push is dropped: no change to storage, `count` or `data_rd`.
  - **Pop only** (`wr_en`=0, `rd_en`=1):
    - If not empty, `data_rd` <= storage[`count`-1], then `count` -= 1.
    - If empty, the pop is ignored: `data_rd` holds its previous value and `count` stays 0.
  - **Push and pop together** (`wr_en`=1, `rd_en`=1):
    - `data_rd` <= `data_wr` (bypass).
    - `count` and storage are unchanged.
    - This applies at any occupancy, including empty and full.
  - **Idle:** all state holds, and `data_rd` keeps its last value.
- **No wrap-around.** `count` saturates at 0 and at `DEPTH`; an overflowing push or underflowing pop never corrupts state.
- **No handshake.** `wr_en` and `rd_en` are level requests evaluated every cycle, and back-to-back operations are allowed every cycle.

## Timing
- **Pop latency:** one edge. `data_rd` shows the popped word just after the edge that sampled `rd_en`=1.
- **Bypass latency:** one edge. `data_rd` equals the `data_wr` sampled at that same edge.
- **Flags:** change just after the edge that changes `count`, with no additional latency.
  - After a push at edge N, `lifo_empty` is already 0 following edge N.
  - After the `DEPTH`-th push, `lifo_full` = 1 following that edge.
- **Consecutive pops** return words in strict reverse push order, one per cycle.
- **After reset release:** `lifo_empty` = 1, `lifo_full` = 0, `data_rd` = 0 until the first pop or bypass.

## Test plan
- **Reset:**
  - Drive `rst`=0 for 5 cycles, then release.
  - Expect `lifo_empty`=1, `lifo_full`=0, `data_rd`=0.
  - With `rst`=0 and `wr_en`=1 asserted, `count` stays 0.
- **Fill and overflow** (DEPTH=12):
  - Push 0x01..0x0C on consecutive cycles.
  - `lifo_full`=0 after each of the first 11 pushes and `lifo_full`=1 after the 12th.
  - A 13th push of 0xFF is dropped and `lifo_full` stays 1.
- **Drain and underflow:**
  - From full, pop 12 times on consecutive cycles; `data_rd` = 0x0C, 0x0B, …, 0x01.
  - `lifo_empty`=1 after the last pop.
  - A 13th pop leaves `data_rd`=0x01 and `lifo_empty`=1.
- **Bypass:**
  - With 3 entries (0x11, 0x22, 0x33), hold `wr_en`=`rd_en`=1 for data 0xA0, 0xA1, 0xA2.
  - `data_rd` follows 0xA0, 0xA1, 0xA2 one edge later.
  - Afterwards, 3 pops return 0x33, 0x22, 0x11.
- **Bypass at boundaries:**
  - When empty, a simultaneous push/pop of 0x5A gives `data_rd`=0x5A and `lifo_empty` stays 1.
  - When full, a simultaneous push/pop of 0x7E gives `data_rd`=0x7E and `lifo_full` stays 1.
- **Mixed random:**
  - Random bursts of push, pop and push+pop, checked against a queue model.
  - Checks cover every `data_rd` value and every flag, plus a mid-sequence reset, after which the model is cleared.
